adc_frame_buffer: RTL and testbench
===================================

# adc_frame_buffer

Downstream consumer of the ADC sampling stage: captures each 12-bit sample flagged by the one-cycle `new_sample_in` pulse, converts it to the processing word format, and packs consecutive samples into fixed-length frames. Frames are held in a two-bank ping-pong buffer: one bank fills while the other drains. Each complete frame is streamed to the processing chain over a valid/ready interface, with an end-of-frame marker on the last sample.

## Interface
Parameters:
- `FRAME_LEN`, 256: samples per frame.
  - Must be a power of two and ≥ 2.
- `DATA_W`, 16: output sample width.
  - Must be ≥ 13.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  12  unsigned ADC code.
  - Valid in the cycle `new_sample_in` is high.
- `new_sample_in`  in  1  one-cycle pulse; capture `sample_in` this cycle.
- `out_data`  out  DATA_W  converted sample.
- `out_valid`  out  1  `out_data` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_last`  out  1  high on sample index FRAME_LEN-1 of a frame.
- `overflow`  out  1  sticky: at least one sample was dropped.
- `clear_overflow`  in  1  clears `overflow`.

## Operation
- Bank states: EMPTY → FILLING → FULL → READING → EMPTY.
- Write side holds a bank pointer `wb` and an index `wi` (log2(FRAME_LEN) bits).
  - On `new_sample_in`, if bank `wb` is EMPTY or FILLING: write the converted sample at `wi` and increment `wi`. The bank becomes FILLING.
  - When `wi` wraps from FRAME_LEN-1 to 0: the bank becomes FULL and `wb` toggles.
- Dropped samples:
  - If `new_sample_in` arrives and bank `wb` is FULL or READING, the sample is discarded and `overflow` is set.
  - `wi` stays 0, so writing resumes at index 0 once that bank returns to EMPTY.
  - Frames are never partial or spliced.
- Read side FSM:
  - IDLE: when the bank at read pointer `rb` is FULL, mark it READING and go to STREAM.
  - STREAM: present words in index order. Advance on each handshake.
  - After the handshake on index FRAME_LEN-1: the bank becomes EMPTY, `rb` toggles, and the FSM returns to IDLE.
- Frames are emitted strictly in capture order.
- Width rule: default output is zero-extended `{(DATA_W-12)'b0, sample_in}`. See Configuration for the signed alternative.
- Overflow flag:
  - Set wins over `clear_overflow` in the same cycle.
  - Otherwise `clear_overflow` drives it to 0 on the next edge.
- Reset value of every output is 0.
- Reset at any point:
  - Both banks return to EMPTY.
  - `wb`, `rb` and `wi` go to 0, and the read FSM goes to IDLE.
  - Partial and unread frames are discarded.
  - Buffer RAM contents need no reset.

## Timing
- Buffer storage is synchronous-read RAM with 1-cycle read latency. It must be inferable as block RAM.
- Last write of a frame on edge N means the bank is FULL after edge N.
  - The first word has `out_valid=1` after edge N+2.
- While `out_valid && !out_ready`, `out_data`, `out_last` and `out_valid` must hold stable.
- Throughput: with `out_ready` held high, one word per cycle with no bubbles inside a frame.
  - At most 2 idle cycles between frames when the next bank is already FULL.
- Same-cycle write and read: one bank can be FILLING while the other is READING with no stall.
  - A write and a read never touch the same bank.
- `new_sample_in` pulses may be back-to-back, in consecutive cycles. Each pulse is handled independently.

## Configuration
- `ADC_FRAME_SIGNED_EN` defined: output is offset-binary to two's complement.
  - `out_data = sign_extend(sample_in - 12'd2048)` to DATA_W.
  - Code 0 → -2048, code 2048 → 0, code 4095 → +2047.
- Not defined: zero-extended unsigned output, as in Operation.
- No other behaviour changes.

## Test plan
- Reset, then 256 pulses with `sample_in = index`, `out_ready=1`:
  - One frame with `out_data` 0..255 in order.
  - `out_last` only on 255; first `out_valid` 2 cycles after the 256th pulse.
  - `overflow=0`.
- `out_ready` toggled pseudo-randomly while streaming: no word lost or duplicated, and outputs stable during stall cycles.
- `out_ready=0` with 3×256+5 pulses:
  - Frames 0 and 1 are buffered and the rest dropped, with `overflow=1`.
  - After releasing `out_ready`: exactly frames 0 and 1 are output.
  - The next accepted sample lands at index 0 of a new frame.
- Pulse `clear_overflow` in the same cycle as a dropped sample → `overflow` stays 1. Pulse `clear_overflow` alone → 0 next cycle.
- Assert `rst` mid-stream at index 100 of frame 0 while frame 1 is filling:
  - All outputs are 0 next cycle.
  - A subsequent clean 256-sample frame streams correctly.
- Build with `ADC_FRAME_SIGNED_EN`, inputs 0, 2048, 4095 → `out_data` 0xF800, 0x0000, 0x07FF (DATA_W=16).

Source files
------------

// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer between the ADC sampling stage and the processing chain.
// Optional build macro ADC_FRAME_SIGNED_EN selects offset-binary to two's complement conversion.
module adc_frame_buffer #(
  parameter int FRAME_LEN = 256,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       sample_in,
  input  logic              new_sample_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] IDX_MAX = AW'(FRAME_LEN - 1);

  localparam logic [1:0] BANK_EMPTY   = 2'd0;
  localparam logic [1:0] BANK_FILLING = 2'd1;
  localparam logic [1:0] BANK_FULL    = 2'd2;
  localparam logic [1:0] BANK_READING = 2'd3;

  localparam logic [0:0] RD_IDLE   = 1'b0;
  localparam logic [0:0] RD_STREAM = 1'b1;

  logic [1:0]        bank_state_reg [2];
  logic              wb_reg;
  logic [AW-1:0]     wi_reg;
  logic              rb_reg;
  logic [AW-1:0]     ri_reg;
  logic [0:0]        rd_state_reg;
  logic              issued_all_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] ram_q_reg;

  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  logic [DATA_W-1:0] sample_conv;

`ifdef ADC_FRAME_SIGNED_EN
  logic [11:0] sample_offset;
  assign sample_offset = sample_in - 12'd2048;
  assign sample_conv   = {{(DATA_W-12){sample_offset[11]}}, sample_offset};
`else
  assign sample_conv   = {{(DATA_W-12){1'b0}}, sample_in};
`endif

  logic wr_bank_free;
  logic wr_en;
  logic drop;
  logic advance;
  logic rd_en;
  logic rd_start;
  logic frame_done;

  assign wr_bank_free = (bank_state_reg[wb_reg] == BANK_EMPTY) ||
                        (bank_state_reg[wb_reg] == BANK_FILLING);
  assign wr_en        = new_sample_in && wr_bank_free;
  assign drop         = new_sample_in && !wr_bank_free;
  // The RAM output register is the output stage, so it only loads when the slot is free.
  assign advance      = !out_valid_reg || out_ready;
  assign rd_en        = (rd_state_reg == RD_STREAM) && !issued_all_reg && advance;
  assign rd_start     = (rd_state_reg == RD_IDLE) && (bank_state_reg[rb_reg] == BANK_FULL);
  assign frame_done   = out_valid_reg && out_ready && out_last_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wb_reg, wi_reg}] <= sample_conv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q_reg <= '0;
    end else if (rd_en) begin
      ram_q_reg <= mem[{rb_reg, ri_reg}];
    end
  end

  // Write and read sides never touch the same bank: each only acts on states the other ignores.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_state_reg[0] <= BANK_EMPTY;
      bank_state_reg[1] <= BANK_EMPTY;
      wb_reg            <= 1'b0;
      wi_reg            <= '0;
      rb_reg            <= 1'b0;
      ri_reg            <= '0;
      rd_state_reg      <= RD_IDLE;
      issued_all_reg    <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_last_reg      <= 1'b0;
      overflow_reg      <= 1'b0;
    end else begin
      if (wr_en) begin
        wi_reg <= wi_reg + AW'(1);
        if (wi_reg == IDX_MAX) begin
          bank_state_reg[wb_reg] <= BANK_FULL;
          wb_reg                 <= ~wb_reg;
        end else begin
          bank_state_reg[wb_reg] <= BANK_FILLING;
        end
      end

      if (rd_start) begin
        bank_state_reg[rb_reg] <= BANK_READING;
        rd_state_reg           <= RD_STREAM;
      end

      if (rd_en) begin
        ri_reg        <= ri_reg + AW'(1);
        out_valid_reg <= 1'b1;
        out_last_reg  <= (ri_reg == IDX_MAX);
        if (ri_reg == IDX_MAX) begin
          issued_all_reg <= 1'b1;
        end
      end else if (advance) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end

      if (frame_done) begin
        bank_state_reg[rb_reg] <= BANK_EMPTY;
        rb_reg                 <= ~rb_reg;
        rd_state_reg           <= RD_IDLE;
        issued_all_reg         <= 1'b0;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign out_data  = ram_q_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Self-checking bench for adc_frame_buffer: random stimulus against a frame-level queue model.
module tb_adc_frame_buffer;

  localparam int FRAME_LEN = 256;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [11:0]       sample_in = '0;
  logic              new_sample_in = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              overflow;
  logic              clear_overflow = 1'b0;

  always #5 clk = ~clk;

  adc_frame_buffer #(.FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_in      (sample_in),
    .new_sample_in  (new_sample_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: accepted samples accumulate into a partial frame; at most two complete
  // frames may be outstanding (buffered or being drained) before samples are dropped.
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W:0]   got_q[$];
  logic [DATA_W-1:0] part_q[$];
  int                pending  = 0;
  int                hs_count = 0;
  logic              ovf_exp  = 1'b0;

  function automatic logic [DATA_W-1:0] conv(input logic [11:0] s);
`ifdef ADC_FRAME_SIGNED_EN
    int v;
    v = int'(s) - 2048;
    return v[DATA_W-1:0];
`else
    return DATA_W'(s);
`endif
  endfunction

  task automatic tick();
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      part_q.delete();
      pending  = 0;
      hs_count = 0;
      ovf_exp  = 1'b0;
    end else begin
      if (new_sample_in && pending >= 2) begin
        ovf_exp = 1'b1;
      end else begin
        if (clear_overflow) ovf_exp = 1'b0;
        if (new_sample_in) begin
          part_q.push_back(conv(sample_in));
          if (part_q.size() == FRAME_LEN) begin
            for (int i = 0; i < FRAME_LEN; i++) exp_q.push_back({i == FRAME_LEN - 1, part_q[i]});
            part_q.delete();
            pending++;
          end
        end
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        if (hs_count % FRAME_LEN == FRAME_LEN - 1) pending--;
        hs_count++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    new_sample_in = 1'b0;
    clear_overflow = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_single_frame();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      new_sample_in = 1'b1;
      sample_in = 12'(i);
      tick();
    end
    new_sample_in = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat0: out_valid got %b want 0", out_valid); end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_lat1: out_valid got %b want 0", out_valid); end
    tick();
    n_vec += 2;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_lat2: out_valid got %b want 1", out_valid); end
    if (out_data !== conv(12'd0)) begin n_err++; $display("FAIL single_first: out_data got %h want %h", out_data, conv(12'd0)); end
    for (int c = 0; c < 4000 && got_q.size() < exp_q.size(); c++) tick();
    repeat (8) tick();
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL single_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL single_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL single_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_ready_toggle();
    logic            stalled;
    logic [DATA_W:0] pword;
    do_reset();
    for (int c = 0; c < 1400; c++) begin
      new_sample_in = ($urandom_range(0, 2) != 0);
      sample_in = 12'($urandom_range(0, 4095));
      out_ready = $urandom_range(0, 1) == 1;
      stalled = out_valid && !out_ready;
      pword = {out_last, out_data};
      tick();
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== pword) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, {out_last, out_data}, pword);
        end
      end
    end
    new_sample_in = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4000 && got_q.size() < exp_q.size(); c++) tick();
    repeat (8) tick();
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL toggle_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL toggle_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_vec++;
    if (overflow !== ovf_exp) begin n_err++; $display("FAIL toggle_overflow: got %b want %b", overflow, ovf_exp); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 3 * FRAME_LEN + 5; i++) begin
      new_sample_in = 1'b1;
      sample_in = 12'($urandom_range(0, 4095));
      tick();
    end
    new_sample_in = 1'b0;
    n_vec++;
    if (overflow !== ovf_exp) begin n_err++; $display("FAIL ovf_set: got %b want %b", overflow, ovf_exp); end
    new_sample_in = 1'b1;
    clear_overflow = 1'b1;
    tick();
    new_sample_in = 1'b0;
    clear_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    out_ready = 1'b1;
    for (int c = 0; c < 4000 && got_q.size() < exp_q.size(); c++) tick();
    repeat (8) tick();
    n_vec++;
    if (got_q.size() !== 2 * FRAME_LEN) begin n_err++; $display("FAIL ovf_count: got %0d words want %0d", got_q.size(), 2 * FRAME_LEN); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < FRAME_LEN; i++) begin
      new_sample_in = 1'b1;
      sample_in = 12'($urandom_range(0, 4095));
      tick();
    end
    new_sample_in = 1'b0;
    for (int c = 0; c < 4000 && got_q.size() < exp_q.size(); c++) tick();
    repeat (8) tick();
    n_vec++;
    if (got_q.size() !== FRAME_LEN) begin n_err++; $display("FAIL ovf_next_count: got %0d words want %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_next_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_midstream_reset();
    int c;
    do_reset();
    out_ready = 1'b1;
    c = 0;
    while (hs_count < 100 && c < 2000) begin
      new_sample_in = 1'b1;
      sample_in = 12'($urandom_range(0, 4095));
      tick();
      c++;
    end
    new_sample_in = 1'b0;
    n_vec++;
    if (hs_count != 100) begin n_err++; $display("FAIL mid_reach: got %0d words want 100", hs_count); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
    if (out_last !== 1'b0) begin n_err++; $display("FAIL mid_rst_last: got %b want 0", out_last); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_overflow: got %b want 0", overflow); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      new_sample_in = 1'b1;
      sample_in = 12'($urandom_range(0, 4095));
      tick();
    end
    new_sample_in = 1'b0;
    for (int k = 0; k < 4000 && got_q.size() < exp_q.size(); k++) tick();
    repeat (8) tick();
    n_vec++;
    if (got_q.size() !== FRAME_LEN) begin n_err++; $display("FAIL mid_after_count: got %0d words want %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mid_after_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_conversion();
    logic [11:0]       codes [3];
    logic [DATA_W-1:0] want  [3];
    logic [DATA_W:0]   w;
    codes[0] = 12'd0;
    codes[1] = 12'd2048;
    codes[2] = 12'd4095;
`ifdef ADC_FRAME_SIGNED_EN
    want[0] = 16'hF800;
    want[1] = 16'h0000;
    want[2] = 16'h07FF;
`else
    want[0] = 16'h0000;
    want[1] = 16'h0800;
    want[2] = 16'h0FFF;
`endif
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      new_sample_in = 1'b1;
      sample_in = (i < 3) ? codes[i] : 12'($urandom_range(0, 4095));
      tick();
    end
    new_sample_in = 1'b0;
    for (int c = 0; c < 4000 && got_q.size() < exp_q.size(); c++) tick();
    repeat (8) tick();
    n_vec++;
    if (got_q.size() !== FRAME_LEN) begin n_err++; $display("FAIL conv_count: got %0d words want %0d", got_q.size(), FRAME_LEN); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      w = got_q[i];
      n_vec++;
      if (w[DATA_W-1:0] !== want[i]) begin n_err++; $display("FAIL conv_code[%0d]: got %h want %h", i, w[DATA_W-1:0], want[i]); end
    end
    for (int i = 3; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL conv_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_ready_toggle();
    test_overflow();
    test_midstream_reset();
    test_conversion();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
